// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin pick function for the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } arb_state_t;

  // Widest requester count the pick function can search.
  localparam int unsigned RR_MAX  = 32;
  localparam int unsigned RR_ID_W = 5;

  typedef struct packed {
    logic               found;
    logic [RR_ID_W-1:0] id;
  } rr_pick_t;

  // Search last+1, last+2, ... modulo n and return the first set valid bit.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]  valid,
                                       input logic [RR_ID_W-1:0] last,
                                       input int unsigned        n);
    rr_pick_t           r;
    logic [RR_ID_W-1:0] idx;
    r.found = 1'b0;
    r.id    = '0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = RR_ID_W'((32'(last) + k) % n);
      if (k <= n && !r.found && valid[idx]) begin
        r.found = 1'b1;
        r.id    = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Purely combinational round-robin selector over NUM_REQ request lines.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_vld
);

  logic [RR_MAX-1:0] req_ext;
  rr_pick_t          pick;

  // Widen the request vector to the function's fixed width and pick a winner.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_pick(req_ext, RR_ID_W'(last), NUM_REQ);
    grant_id               = ID_WIDTH'(pick.id);
    grant_vld              = pick.found;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port SRAM.
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; ready is combinational from valid and is
// one-hot or zero. Every transfer gets exactly one rsp_valid pulse one
// cycle later, with no backpressure on the response side.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int SIZE        = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int INIT_CYCLES = 4,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            sram_rst_n,
  output logic [ADDR_WIDTH-1:0]           sram_addr,
  output logic                            sram_re,
  output logic                            sram_we,
  output logic [DATA_WIDTH-1:0]           sram_data_in,
  input  logic [DATA_WIDTH-1:0]           sram_data_out
);

  localparam int CNT_W = $clog2(INIT_CYCLES) + 1;

  arb_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ID_WIDTH-1:0] rr_last;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_vld;
  logic                grant;
  logic                pending;
  logic                pend_rd;
  logic [ID_WIDTH-1:0] pend_id;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .last      (rr_last),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  // FSM state and init counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: hold the SRAM in clear for INIT_CYCLES, then serve traffic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sram_rst_n = 1'b0;
    grant      = 1'b0;
    case (state)
      INIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        sram_rst_n = 1'b1;
        grant      = grant_vld;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Steer the granted requester onto the SRAM port; idle drives zeros.
  always_comb begin
    int unsigned gi;
    gi           = 32'(grant_id);
    req_ready    = '0;
    sram_re      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_data_in = '0;
    if (grant) begin
      req_ready[grant_id] = 1'b1;
      sram_addr           = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      if (req_we[grant_id]) begin
        sram_we      = 1'b1;
        sram_data_in = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sram_re = 1'b1;
      end
    end
  end

  // Rotate priority past each winner and remember who gets the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= ID_WIDTH'(NUM_REQ - 1);
      pending <= 1'b0;
      pend_id <= '0;
      pend_rd <= 1'b0;
    end else begin
      pending <= grant;
      if (grant) begin
        rr_last <= grant_id;
        pend_id <= grant_id;
        pend_rd <= !req_we[grant_id];
      end
    end
  end

  // Response pulse one cycle after the grant; data only for reads.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (pending) begin
      rsp_valid[pend_id] = 1'b1;
      if (pend_rd) rsp_rdata = sram_data_out;
    end
  end

  // The SRAM port never reads and writes at once, and callers keep addr < SIZE.
  a_no_rw_overlap: assert property (@(posedge clk) disable iff (rst)
    !(sram_re && sram_we));
  a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
    (sram_re || sram_we) |-> (32'(sram_addr) < SIZE));

endmodule
